pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Controls the Gowin rPLL that generates the 96 MHz video clock from the 27 MHz reference.
- Holds the PLL in reset at power-up, waits for lock, and requires lock to stay stable before releasing the downstream video reset.
- Watches for loss of lock and restarts the PLL with bounded retries, flagging a fault when retries run out.
- Runs in the 27 MHz reference domain, because the PLL output is not trustworthy before lock.

Parameters:
- RESET_CYCLES, 16: cycles pll_reset is held high per PLL reset pulse (≥2).
- SETTLE_CYCLES, 1024: consecutive cycles of synchronized lock required before release (≥1).
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before a retry (≥1).
- MAX_RETRIES, 3: timeouts tolerated before FAULT.
- RETRY_W, 2: width of retry_cnt; must hold MAX_RETRIES.

Ports:
- clk  in  1  27 MHz reference clock, same net as PLL clkin.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock_async  in  1  PLL lock output; asynchronous to clk.
- restart  in  1  synchronous soft-restart request, level-sampled.
- pll_reset  out  1  drives the rPLL RESET pin; active high.
- out_rst_n  out  1  downstream video-domain reset request; active low; registered.
- running  out  1  high while in RUN.
- fault  out  1  high while in FAULT.
- retry_cnt  out  RETRY_W  timeouts since the last RUN entry or restart.
- loss_cnt  out  8  lock losses while in RUN; saturates at 255.

Behaviour:
- Reset (rst_n=0): outputs take their reset values immediately and asynchronously.
  - pll_reset=1, out_rst_n=0, running=0, fault=0, retry_cnt=0, loss_cnt=0.
  - state=RESET_PLL, cycle counter=0.
- Lock synchronizer: pll_lock_async passes through a 2-FF synchronizer to give lock_s. Latency is 2 cycles. The synchronizer flops reset to 0.
- One shared cycle counter, width clog2 of the largest of the three cycle parameters. It clears on every state change.
- States and transitions:
  - RESET_PLL:
    - pll_reset=1; counter counts to RESET_CYCLES-1.
    - Then go to WAIT_LOCK; pll_reset=0 from the next cycle.
    - pll_reset is therefore high for exactly RESET_CYCLES cycles after rst_n deasserts.
  - WAIT_LOCK:
    - lock_s=1: go to SETTLE.
    - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 and retry_cnt<MAX_RETRIES: increment retry_cnt, go to RESET_PLL.
    - Timeout with retry_cnt==MAX_RETRIES: go to FAULT.
  - SETTLE:
    - Counter increments on each lock_s=1 cycle.
    - lock_s=0: go to WAIT_LOCK; the timeout counter restarts from 0.
    - lock_s=1 at count SETTLE_CYCLES-1: go to RUN.
    - out_rst_n=1 and running=1 register on that same edge.
  - RUN:
    - out_rst_n=1, running=1, retry_cnt cleared on entry.
    - lock_s=0: next edge sets out_rst_n=0 and running=0, increments loss_cnt (saturating), and goes to RESET_PLL.
  - FAULT:
    - pll_reset=1, out_rst_n=0, fault=1.
    - Leaves FAULT only on restart or rst_n.
- restart=1 has priority over every other transition in any state:
  - Next state RESET_PLL; retry_cnt=0; fault=0; out_rst_n=0; running=0.
  - loss_cnt is not incremented, even if lock_s drops in the same cycle.
- out_rst_n rise latency: 2 (sync) + SETTLE_CYCLES cycles after pll_lock_async rises, provided lock stays high.
- out_rst_n fall latency after lock loss: at most 3 cycles (2 sync + 1 registered).
- pll_reset is low only in WAIT_LOCK, SETTLE and RUN.
- Downstream logic synchronizes out_rst_n into the 96 MHz domain. That synchronizer is not part of this block.

Decomposition:
- Package pll_seq_pkg:
  - state enum typedef (RESET_PLL, WAIT_LOCK, SETTLE, RUN, FAULT).
  - LOSS_CNT_W=8 constant.
- Sub-module sync_2ff: single-bit 2-flop synchronizer with async active-low reset and parameterised reset value. It is reused elsewhere for async inputs.

Test Plan:
All scenarios use RESET_CYCLES=4, SETTLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
1. Power-up: release rst_n at cycle 0, raise lock at cycle 10 -> pll_reset high for cycles 0–3, out_rst_n and running rise at cycle 20 (10+2+8), retry_cnt=0.
2. Settle glitch: lock drops for 1 cycle at the 5th settle cycle, then returns -> no release at cycle 20; out_rst_n rises 2+8 cycles after lock returns.
3. No lock ever -> retry_cnt 1 then 2 with a 4-cycle pll_reset pulse per timeout; third timeout sets fault=1 and pll_reset=1 held; restart pulse clears fault and retry_cnt and starts a new RESET_PLL.
4. Loss in RUN: lock falls -> out_rst_n=0 within 3 cycles, loss_cnt 0->1, 4-cycle pll_reset pulse; relock gives RUN again with loss_cnt still 1.
5. restart asserted in the same cycle lock_s falls in RUN -> RESET_PLL, loss_cnt unchanged; force 256 losses -> loss_cnt stays at 255.
6. rst_n asserted mid-SETTLE -> all outputs at reset values in the same cycle, without waiting for a clk edge; after release, sequence restarts per scenario 1.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      StResetPll,
      StWaitLock,
      StSettle,
      StRun,
      StFault
   } pll_state_e;

   localparam int unsigned LOSS_CNT_W = 8;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs; reset value is a parameter.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[0], d_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences rPLL reset, lock qualification and loss-of-lock recovery in the reference domain.
// All outputs are registered decodes of the next state.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned RETRY_W       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_lock_async,
   input  logic                  restart,
   output logic                  pll_reset,
   output logic                  out_rst_n,
   output logic                  running,
   output logic                  fault,
   output logic [RETRY_W-1:0]    retry_cnt,
   output logic [LOSS_CNT_W-1:0] loss_cnt
);

   localparam int unsigned CntMax = max3(RESET_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);
   localparam int unsigned CNT_W  = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [CNT_W-1:0]   RstLast     = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RetryMax    = RETRY_W'(MAX_RETRIES);

   if (RESET_CYCLES < 2) begin : g_bad_reset_cycles
      $error("RESET_CYCLES must be at least 2");
   end
   if (SETTLE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_cycles
      $error("SETTLE_CYCLES and LOCK_TIMEOUT must be at least 1");
   end
   if (MAX_RETRIES >= (1 << RETRY_W)) begin : g_bad_retry_w
      $error("RETRY_W too narrow for MAX_RETRIES");
   end

   pll_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [RETRY_W-1:0]     retry_q, retry_d;
   logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
   logic                   pll_reset_q, pll_reset_d;
   logic                   out_rst_n_q, out_rst_n_d;
   logic                   running_q, running_d;
   logic                   fault_q, fault_d;
   logic                   lock_s;

   sync_2ff #(
      .RESET_VAL (1'b0)
   ) u_lock_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (pll_lock_async),
      .q_o    (lock_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      loss_d  = loss_q;

      if (restart) begin
         state_d = StResetPll;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         unique case (state_q)
            StResetPll: begin
               if (cnt_q == RstLast) begin
                  state_d = StWaitLock;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            StWaitLock: begin
               if (lock_s) begin
                  // The cycle that first sees lock counts as the first settle cycle.
                  if (SETTLE_CYCLES == 1) begin
                     state_d = StRun;
                     cnt_d   = '0;
                     retry_d = '0;
                  end else begin
                     state_d = StSettle;
                     cnt_d   = CNT_W'(1);
                  end
               end else if (cnt_q == TimeoutLast) begin
                  cnt_d = '0;
                  if (retry_q < RetryMax) begin
                     retry_d = retry_q + 1'b1;
                     state_d = StResetPll;
                  end else begin
                     state_d = StFault;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            StSettle: begin
               if (!lock_s) begin
                  state_d = StWaitLock;
                  cnt_d   = '0;
               end else if (cnt_q == SettleLast) begin
                  state_d = StRun;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            StRun: begin
               retry_d = '0;
               if (!lock_s) begin
                  state_d = StResetPll;
                  cnt_d   = '0;
                  if (loss_q != '1) begin
                     loss_d = loss_q + 1'b1;
                  end
               end
            end

            StFault: begin
               cnt_d = '0;
            end

            default: begin
               state_d = StResetPll;
               cnt_d   = '0;
            end
         endcase
      end

      pll_reset_d = (state_d == StResetPll) || (state_d == StFault);
      out_rst_n_d = (state_d == StRun);
      running_d   = (state_d == StRun);
      fault_d     = (state_d == StFault);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StResetPll;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= '0;
         pll_reset_q <= 1'b1;
         out_rst_n_q <= 1'b0;
         running_q   <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_reset_q <= pll_reset_d;
         out_rst_n_q <= out_rst_n_d;
         running_q   <= running_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset = pll_reset_q;
   assign out_rst_n = out_rst_n_q;
   assign running   = running_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: cycle-indexed expectation tables feed a scoreboard
// queue that is drained at the falling edge of each cycle.
module tb_pll_lock_sequencer;

   localparam int unsigned RST_C = 4;
   localparam int unsigned SET_C = 8;
   localparam int unsigned TO_C  = 32;
   localparam int unsigned MAX_R = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lock = 1'b0;
   logic       restart = 1'b0;
   logic       pll_reset, out_rst_n, running, fault;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   int cyc = 0;
   int base = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int          n;
      string       name;
      logic [13:0] v;
   } vec_t;

   typedef struct {
      int          cyc;
      string       name;
      logic [13:0] v;
   } exp_t;

   exp_t sb[$];
   vec_t pu_tbl[6];
   vec_t nl_tbl[13];

   pll_lock_sequencer #(
      .RESET_CYCLES  (RST_C),
      .SETTLE_CYCLES (SET_C),
      .LOCK_TIMEOUT  (TO_C),
      .MAX_RETRIES   (MAX_R),
      .RETRY_W       (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pll_lock_async (lock),
      .restart        (restart),
      .pll_reset      (pll_reset),
      .out_rst_n      (out_rst_n),
      .running        (running),
      .fault          (fault),
      .retry_cnt      (retry_cnt),
      .loss_cnt       (loss_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: got no summary by time limit, want completion");
      $fatal(1, "simulation time limit reached");
   end

   function automatic logic [13:0] pk(input logic pr, input logic orn, input logic run,
                                      input logic flt, input logic [1:0] rc,
                                      input logic [7:0] lc);
      return {pr, orn, run, flt, rc, lc};
   endfunction

   function automatic logic [13:0] dut_vec();
      return {pll_reset, out_rst_n, running, fault, retry_cnt, loss_cnt};
   endfunction

   task automatic cmp(input string name, input logic [13:0] got, input logic [13:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b (pll_reset,out_rst_n,running,fault,retry[2],loss[8])",
                  name, got, want);
      end
   endtask

   task automatic fail_tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no transition within bound, want transition", name);
   endtask

   task automatic push(input int n, input string name, input logic [13:0] v);
      exp_t e;
      e.cyc  = base + n;
      e.name = name;
      e.v    = v;
      sb.push_back(e);
   endtask

   task automatic check_due();
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: got no sample at cycle %0d, want sampled", e.name, e.cyc - base);
         end else begin
            cmp(e.name, dut_vec(), e.v);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_due();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int n);
      while (cyc < base + n) step();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      restart = 1'b0;
      lock    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base  = cyc;
   endtask

   task automatic run_powerup();
      foreach (pu_tbl[i]) push(pu_tbl[i].n, pu_tbl[i].name, pu_tbl[i].v);
      goto(10);
      lock = 1'b1;
      goto(25);
   endtask

   initial begin
      int k;
      logic [7:0] expl;

      pu_tbl[0] = '{0,  "pu_c0",      pk(1, 0, 0, 0, 2'd0, 8'd0)};
      pu_tbl[1] = '{3,  "pu_c3",      pk(1, 0, 0, 0, 2'd0, 8'd0)};
      pu_tbl[2] = '{4,  "pu_c4",      pk(0, 0, 0, 0, 2'd0, 8'd0)};
      pu_tbl[3] = '{19, "pu_c19",     pk(0, 0, 0, 0, 2'd0, 8'd0)};
      pu_tbl[4] = '{20, "pu_release", pk(0, 1, 1, 0, 2'd0, 8'd0)};
      pu_tbl[5] = '{24, "pu_c24",     pk(0, 1, 1, 0, 2'd0, 8'd0)};

      nl_tbl[0]  = '{35,  "nl_c35",     pk(0, 0, 0, 0, 2'd0, 8'd0)};
      nl_tbl[1]  = '{36,  "nl_retry1",  pk(1, 0, 0, 0, 2'd1, 8'd0)};
      nl_tbl[2]  = '{39,  "nl_c39",     pk(1, 0, 0, 0, 2'd1, 8'd0)};
      nl_tbl[3]  = '{40,  "nl_c40",     pk(0, 0, 0, 0, 2'd1, 8'd0)};
      nl_tbl[4]  = '{71,  "nl_c71",     pk(0, 0, 0, 0, 2'd1, 8'd0)};
      nl_tbl[5]  = '{72,  "nl_retry2",  pk(1, 0, 0, 0, 2'd2, 8'd0)};
      nl_tbl[6]  = '{76,  "nl_c76",     pk(0, 0, 0, 0, 2'd2, 8'd0)};
      nl_tbl[7]  = '{107, "nl_c107",    pk(0, 0, 0, 0, 2'd2, 8'd0)};
      nl_tbl[8]  = '{108, "nl_fault",   pk(1, 0, 0, 1, 2'd2, 8'd0)};
      nl_tbl[9]  = '{150, "nl_held",    pk(1, 0, 0, 1, 2'd2, 8'd0)};
      nl_tbl[10] = '{151, "nl_restart", pk(1, 0, 0, 0, 2'd0, 8'd0)};
      nl_tbl[11] = '{154, "nl_c154",    pk(1, 0, 0, 0, 2'd0, 8'd0)};
      nl_tbl[12] = '{155, "nl_c155",    pk(0, 0, 0, 0, 2'd0, 8'd0)};

      // Power-up
      do_reset();
      run_powerup();

      // Lock glitch during settle
      do_reset();
      push(20, "gl_no_release", pk(0, 0, 0, 0, 2'd0, 8'd0));
      push(24, "gl_c24",        pk(0, 0, 0, 0, 2'd0, 8'd0));
      push(25, "gl_release",    pk(0, 1, 1, 0, 2'd0, 8'd0));
      goto(10);
      lock = 1'b1;
      goto(14);
      lock = 1'b0;
      goto(15);
      lock = 1'b1;
      goto(26);

      // No lock: retries, fault, restart
      do_reset();
      foreach (nl_tbl[i]) push(nl_tbl[i].n, nl_tbl[i].name, nl_tbl[i].v);
      goto(150);
      restart = 1'b1;
      step();
      restart = 1'b0;
      goto(156);

      // Loss in RUN, relock, then restart coinciding with lock loss
      do_reset();
      push(20, "loss_run",      pk(0, 1, 1, 0, 2'd0, 8'd0));
      push(32, "loss_c32",      pk(0, 1, 1, 0, 2'd0, 8'd0));
      push(33, "loss_fall",     pk(1, 0, 0, 0, 2'd0, 8'd1));
      push(36, "loss_c36",      pk(1, 0, 0, 0, 2'd0, 8'd1));
      push(37, "loss_c37",      pk(0, 0, 0, 0, 2'd0, 8'd1));
      push(49, "relock_c49",    pk(0, 0, 0, 0, 2'd0, 8'd1));
      push(50, "relock_run",    pk(0, 1, 1, 0, 2'd0, 8'd1));
      push(62, "rs_c62",        pk(0, 1, 1, 0, 2'd0, 8'd1));
      push(63, "rs_no_loss",    pk(1, 0, 0, 0, 2'd0, 8'd1));
      goto(10);
      lock = 1'b1;
      goto(30);
      lock = 1'b0;
      goto(40);
      lock = 1'b1;
      goto(60);
      lock = 1'b0;
      goto(62);
      restart = 1'b1;
      step();
      restart = 1'b0;
      lock    = 1'b1;
      step();

      // Saturate the loss counter
      for (int i = 0; i < 256; i++) begin
         k = 0;
         while (running !== 1'b1 && k < 60) begin
            step();
            k++;
         end
         if (running !== 1'b1) fail_tmo($sformatf("sat_run_%0d", i));
         lock = 1'b0;
         k = 0;
         while (running !== 1'b0 && k < 6) begin
            step();
            k++;
         end
         if (running !== 1'b0) fail_tmo($sformatf("sat_fall_%0d", i));
         expl = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
         push(cyc - base, $sformatf("sat_loss_%0d", i), pk(1, 0, 0, 0, 2'd0, expl));
         step();
         lock = 1'b1;
      end

      // Asynchronous reset mid-settle
      do_reset();
      push(14, "ar_settle", pk(0, 0, 0, 0, 2'd0, 8'd0));
      goto(10);
      lock = 1'b1;
      goto(15);
      #2;
      rst_n = 1'b0;
      lock  = 1'b0;
      #1;
      cmp("ar_async", dut_vec(), pk(1, 0, 0, 0, 2'd0, 8'd0));
      do_reset();
      run_powerup();

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
